// File: rtl/eth_pkg.sv
// Shared constants, fill-state encoding and helpers for the receive FCS checker.
package eth_pkg;

  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;

  localparam int unsigned ETH_MIN_LEN = 64;
  localparam int unsigned ETH_MAX_LEN = 1518;

  // Occupancy of the 4-byte delay line that hides the trailing FCS.
  typedef enum logic [1:0] {
    FILL_IDLE   = 2'd0,   // empty, waiting for a frame's first byte
    FILL_PART   = 2'd1,   // 1..3 bytes held, nothing emitted yet
    FILL_STREAM = 2'd2    // 4 bytes held, every new byte pushes one out
  } fill_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/crc32.sv
// Combinational reflected CRC step: folds DATA_WIDTH bits, LSB first, into the state.
module crc32 #(
  parameter int unsigned            DATA_WIDTH = 8,
  parameter int unsigned            CRC_WIDTH  = 32,
  parameter logic [CRC_WIDTH-1:0]   POLY       = 32'hEDB88320
) (
  input  logic [CRC_WIDTH-1:0]  crc_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [CRC_WIDTH-1:0]  crc_o
);

  logic [CRC_WIDTH-1:0] chain [0:DATA_WIDTH];

  assign chain[0] = crc_i;

  // One shift-and-conditional-xor stage per input bit.
  generate
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit
      assign chain[gi+1] = {1'b0, chain[gi][CRC_WIDTH-1:1]}
                         ^ ({CRC_WIDTH{chain[gi][0] ^ data_i[gi]}} & POLY);
    end
  endgenerate

  assign crc_o = chain[DATA_WIDTH];

endmodule

// File: rtl/eth_fcs_check.sv
// Receive-side FCS checker/stripper: CRC over every byte, payload delayed by
// four bytes so the FCS never reaches the output, status on the last payload byte.
module eth_fcs_check
  import eth_pkg::*;
#(
  parameter int unsigned MIN_LEN = ETH_MIN_LEN,
  parameter int unsigned MAX_LEN = ETH_MAX_LEN,
  parameter logic [31:0] POLY    = CRC_POLY,
  parameter logic [31:0] RESIDUE = CRC_RESIDUE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic        out_fcs_ok,
  output logic        out_len_err,
  output logic        out_runt,
  output logic [15:0] cnt_good,
  output logic [15:0] cnt_bad
);

  fill_state_e state_q, state_d;
  logic [2:0]  fill_q, fill_d;
  logic [31:0] crc_q, crc_d, crc_step;
  logic [7:0]  dl_q [4];
  logic [7:0]  dl_d [4];
  logic [15:0] len_q, len_d, len_inc;
  logic        len_err;

  logic        out_valid_q, out_valid_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_last_q, out_last_d;
  logic        out_fcs_ok_q, out_fcs_ok_d;
  logic        out_len_err_q, out_len_err_d;
  logic        out_runt_q, out_runt_d;
  logic [15:0] cnt_good_q, cnt_good_d;
  logic [15:0] cnt_bad_q, cnt_bad_d;

  crc32 #(.DATA_WIDTH(8), .CRC_WIDTH(32), .POLY(POLY)) u_crc (
    .crc_i  (crc_q),
    .data_i (in_data),
    .crc_o  (crc_step)
  );

  // Length includes the byte being accepted now, so the in_last byte counts.
  assign len_inc = sat_inc16(len_q);
  assign len_err = ({16'd0, len_inc} < MIN_LEN) || ({16'd0, len_inc} > MAX_LEN);

  // Next-state: shift the delay line, advance CRC/length, build registered outputs.
  always_comb begin
    state_d       = state_q;
    fill_d        = fill_q;
    crc_d         = crc_q;
    len_d         = len_q;
    dl_d          = dl_q;
    out_valid_d   = 1'b0;
    out_data_d    = 8'd0;
    out_last_d    = 1'b0;
    out_fcs_ok_d  = 1'b0;
    out_len_err_d = 1'b0;
    out_runt_d    = 1'b0;
    cnt_good_d    = cnt_good_q;
    cnt_bad_d     = cnt_bad_q;

    if (in_valid) begin
      crc_d = crc_step;
      len_d = len_inc;
      for (int i = 0; i < 3; i++) dl_d[i] = dl_q[i+1];
      dl_d[3] = in_data;

      // With four bytes held, the oldest is payload and leaves now.
      if (state_q == FILL_STREAM) begin
        out_valid_d = 1'b1;
        out_data_d  = dl_q[0];
      end

      if (in_last) begin
        // Frame done: everything starts clean for a byte on the very next cycle.
        crc_d   = CRC_INIT;
        len_d   = 16'd0;
        fill_d  = 3'd0;
        state_d = FILL_IDLE;
        for (int i = 0; i < 4; i++) dl_d[i] = 8'd0;
        if (state_q == FILL_STREAM) begin
          out_last_d    = 1'b1;
          out_fcs_ok_d  = (crc_step == RESIDUE);
          out_len_err_d = len_err;
          if ((crc_step == RESIDUE) && !len_err) cnt_good_d = sat_inc16(cnt_good_q);
          else                                   cnt_bad_d  = sat_inc16(cnt_bad_q);
        end else begin
          // Nothing beyond the FCS bytes ever arrived.
          out_runt_d = 1'b1;
          cnt_bad_d  = sat_inc16(cnt_bad_q);
        end
      end else begin
        if (fill_q != 3'd4) fill_d = fill_q + 3'd1;
        state_d = (fill_q >= 3'd3) ? FILL_STREAM : FILL_PART;
      end
    end
  end

  // State and output registers; reset discards any partial frame silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FILL_IDLE;
      fill_q        <= 3'd0;
      crc_q         <= CRC_INIT;
      len_q         <= 16'd0;
      for (int i = 0; i < 4; i++) dl_q[i] <= 8'd0;
      out_valid_q   <= 1'b0;
      out_data_q    <= 8'd0;
      out_last_q    <= 1'b0;
      out_fcs_ok_q  <= 1'b0;
      out_len_err_q <= 1'b0;
      out_runt_q    <= 1'b0;
      cnt_good_q    <= 16'd0;
      cnt_bad_q     <= 16'd0;
    end else begin
      state_q       <= state_d;
      fill_q        <= fill_d;
      crc_q         <= crc_d;
      len_q         <= len_d;
      dl_q          <= dl_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_last_q    <= out_last_d;
      out_fcs_ok_q  <= out_fcs_ok_d;
      out_len_err_q <= out_len_err_d;
      out_runt_q    <= out_runt_d;
      cnt_good_q    <= cnt_good_d;
      cnt_bad_q     <= cnt_bad_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_last    = out_last_q;
  assign out_fcs_ok  = out_fcs_ok_q;
  assign out_len_err = out_len_err_q;
  assign out_runt    = out_runt_q;
  assign cnt_good    = cnt_good_q;
  assign cnt_bad     = cnt_bad_q;

endmodule

// File: tb/tb_eth_fcs_check.sv
// Scoreboard bench: two checkers (MIN_LEN=1 and default) share one stimulus stream.
module tb_eth_fcs_check;
  import eth_pkg::*;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    bit         runt;
    logic [7:0] data;
    bit         last;
    bit         ok;
    bit         lerr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_last;
  logic [7:0]  in_data;
  logic        ov [2];
  logic [7:0]  od [2];
  logic        ol [2];
  logic        ok [2];
  logic        le [2];
  logic        rt [2];
  logic [15:0] cg [2];
  logic [15:0] cb [2];

  exp_t q [2][$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_good [2];
  int   exp_bad  [2];

  always #5 clk = ~clk;

  eth_fcs_check #(.MIN_LEN(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .out_valid(ov[0]), .out_data(od[0]), .out_last(ol[0]), .out_fcs_ok(ok[0]),
    .out_len_err(le[0]), .out_runt(rt[0]), .cnt_good(cg[0]), .cnt_bad(cb[0]));

  eth_fcs_check dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .out_valid(ov[1]), .out_data(od[1]), .out_last(ol[1]), .out_fcs_ok(ok[1]),
    .out_len_err(le[1]), .out_runt(rt[1]), .cnt_good(cg[1]), .cnt_bad(cb[1]));

  function automatic int min_len(input int d);
    return (d == 0) ? 1 : 64;
  endfunction

  // Textbook CRC-32 (init all-ones, reflected, final inversion) of a byte list.
  function automatic logic [31:0] crc_of(input bq_t b);
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      c = c ^ {24'd0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Payload followed by its FCS, low byte first; optional single-bit corruption.
  function automatic bq_t make_frame(input int total, input bit corrupt);
    bq_t f;
    logic [31:0] c;
    int pos;
    for (int i = 0; i < total - 4; i++) f.push_back(8'($urandom));
    c = crc_of(f);
    for (int i = 0; i < 4; i++) f.push_back(c[8*i +: 8]);
    if (corrupt) begin
      pos = $urandom_range(0, total - 1);
      f[pos] = f[pos] ^ (8'd1 << $urandom_range(0, 7));
    end
    return f;
  endfunction

  // Expected response of a whole frame: payload list plus a status verdict.
  task automatic push_frame(input bq_t f);
    int n = f.size();
    bq_t pl;
    bit fcs_good, lerr;
    exp_t e;
    for (int i = 0; i < n - 4; i++) pl.push_back(f[i]);
    for (int d = 0; d < 2; d++) begin
      if (n <= 4) begin
        e = '{runt: 1'b1, data: 8'd0, last: 1'b0, ok: 1'b0, lerr: 1'b0};
        q[d].push_back(e);
        exp_bad[d]++;
      end else begin
        fcs_good = (crc_of(pl) == {f[n-1], f[n-2], f[n-3], f[n-4]});
        lerr = (n < min_len(d)) || (n > 1518);
        for (int i = 0; i < n - 4; i++) begin
          e = '{runt: 1'b0, data: f[i], last: (i == n - 5), ok: fcs_good, lerr: lerr};
          q[d].push_back(e);
        end
        if (fcs_good && !lerr) exp_good[d]++;
        else                   exp_bad[d]++;
      end
    end
  endtask

  // An aborted frame of k bytes still releases its first k-4 bytes as payload.
  task automatic push_partial(input bq_t f, input int k);
    exp_t e;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < k - 4; i++) begin
        e = '{runt: 1'b0, data: f[i], last: 1'b0, ok: 1'b0, lerr: 1'b0};
        q[d].push_back(e);
      end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'($urandom_range(0, 1));
    in_data  = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) idle_cycle();
  endtask

  task automatic send_bytes(input bq_t f, input int cnt, input int gap_pct, input bit mark_last);
    for (int i = 0; i < cnt; i++) begin
      if (i != 0) while ($urandom_range(0, 99) < gap_pct) idle_cycle();
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = f[i];
      in_last  = mark_last && (i == cnt - 1);
    end
  endtask

  task automatic send_frame(input bq_t f, input int gap_pct);
    push_frame(f);
    send_bytes(f, f.size(), gap_pct, 1'b1);
  endtask

  task automatic check_counters(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_cnt_good_dut%0d", tag, d), 32'(cg[d]), 32'(exp_good[d]));
      check($sformatf("%s_cnt_bad_dut%0d", tag, d), 32'(cb[d]), 32'(exp_bad[d]));
    end
  endtask

  task automatic check_drained(input string tag);
    for (int d = 0; d < 2; d++)
      check($sformatf("%s_pending_dut%0d", tag, d), 32'(q[d].size()), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'd0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_out_valid_dut%0d", d), 32'(ov[d]), 32'd0);
      check($sformatf("rst_out_data_dut%0d", d), 32'(od[d]), 32'd0);
      check($sformatf("rst_out_last_dut%0d", d), 32'(ol[d]), 32'd0);
      check($sformatf("rst_out_runt_dut%0d", d), 32'(rt[d]), 32'd0);
      check($sformatf("rst_out_fcs_ok_dut%0d", d), 32'(ok[d]), 32'd0);
      check($sformatf("rst_cnt_good_dut%0d", d), 32'(cg[d]), 32'd0);
      check($sformatf("rst_cnt_bad_dut%0d", d), 32'(cb[d]), 32'd0);
      q[d].delete();
      exp_good[d] = 0;
      exp_bad[d]  = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: every presented output is popped against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        if (ov[d] || rt[d]) begin
          if (q[d].size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_output_dut%0d: got valid=%0d runt=%0d data=%0h required no output",
                     d, ov[d], rt[d], od[d]);
          end else begin
            exp_t e;
            e = q[d].pop_front();
            check($sformatf("runt_dut%0d", d), 32'(rt[d]), 32'(e.runt));
            check($sformatf("valid_dut%0d", d), 32'(ov[d]), 32'(!e.runt));
            if (!e.runt) begin
              check($sformatf("data_dut%0d", d), 32'(od[d]), 32'(e.data));
              check($sformatf("last_dut%0d", d), 32'(ol[d]), 32'(e.last));
              if (e.last) begin
                check($sformatf("fcs_ok_dut%0d", d), 32'(ok[d]), 32'(e.ok));
                check($sformatf("len_err_dut%0d", d), 32'(le[d]), 32'(e.lerr));
              end
            end
            if (e.runt || e.last)
              $display("dut%0d frame end: runt=%0d fcs_ok=%0d len_err=%0d good=%0d bad=%0d",
                       d, rt[d], ok[d], le[d], cg[d], cb[d]);
          end
        end
      end
    end
  end

  initial begin
    bq_t kg, bad, f;
    kg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
           8'h26, 8'h39, 8'hF4, 8'hCB};
    do_reset();

    // Known-good frame, then the same frame with one payload byte altered.
    send_frame(kg, 0);
    idle(6);
    check_counters("known_good");
    bad = kg;
    bad[4] = 8'h34;
    send_frame(bad, 0);
    idle(6);
    check_counters("corrupted");

    // Runt, then a 60-byte frame carrying a correct FCS.
    f = '{8'hAA, 8'hBB, 8'hCC};
    send_frame(f, 0);
    idle(6);
    check_counters("runt");
    send_frame(make_frame(60, 1'b0), 0);
    idle(6);

    // Length boundaries around both limits.
    send_frame(make_frame(63, 1'b0), 0);
    send_frame(make_frame(64, 1'b0), 0);
    send_frame(make_frame(1518, 1'b0), 0);
    send_frame(make_frame(1519, 1'b0), 0);
    send_frame(make_frame(5, 1'b0), 0);
    send_frame(make_frame(4, 1'b0), 0);
    idle(6);
    check_counters("boundaries");

    // Gapped known-good frame immediately followed by a second copy.
    send_frame(kg, 30);
    send_frame(kg, 0);
    idle(6);
    check_counters("back_to_back");

    // Random lengths, corruption and gaps.
    for (int n = 0; n < 25; n++)
      send_frame(make_frame($urandom_range(1, 90), 1'($urandom_range(0, 1))),
                 $urandom_range(0, 25));
    idle(6);
    check_counters("random");
    check_drained("random");

    // Reset after six bytes of a frame, then a clean known-good frame.
    push_partial(kg, 6);
    send_bytes(kg, 6, 0, 1'b0);
    @(posedge clk);
    @(negedge clk); #1;
    check_drained("pre_reset");
    do_reset();
    send_frame(kg, 0);
    idle(6);
    check_counters("after_reset");
    check_drained("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
